pic_core_csr: RTL and testbench
===============================

Name: pic_core_csr

Overview:
Programmable interrupt controller core: CSR register file plus interrupt conditioning logic.
Sits directly downstream of the PIC AXI-lite interface and consumes its BRAM-style strobes (bram_addr/bram_wr/bram_wr_data/bram_rd).
Returns bram_rd_data one cycle after a read strobe.
Synchronises, polarity-adjusts, edge/level-qualifies and masks NUM_IRQ external sources, then drives a single registered irq to the CPU.

Parameters:
- ADD_WIDTH, 8, CSR byte-address width; matches the interface block.
- NUM_IRQ, 16, number of interrupt sources, 1..32.

Ports:
- aclk, in, 1: clock.
- areset, in, 1: synchronous, active-high reset.
- bram_addr, in, ADD_WIDTH: CSR byte address; bits [1:0] ignored.
- bram_wr, in, 1: one-cycle write strobe.
- bram_wr_data, in, 32: write data, valid with bram_wr.
- bram_rd, in, 1: one-cycle read strobe.
- bram_rd_data, out, 32: registered read data.
- irq_src, in, NUM_IRQ: asynchronous interrupt sources.
- irq, out, 1: registered interrupt request to the CPU.

Behaviour:
- Reset (areset=1 at a clock edge): all CSRs 0, sync/prev flops 0, bram_rd_data=0, irq=0. Reset mid-operation discards pending and any in-flight read.
- Register map (word offsets). Unmapped reads return 0; unmapped writes are ignored. Bits at or above NUM_IRQ read 0 and ignore writes.
  - 0x00 CTRL RW: [0] global enable.
  - 0x04 ENABLE RW: per-source mask; 1 = enabled.
  - 0x08 EDGE RW: 1 = edge-triggered, 0 = level-triggered.
  - 0x0C POLARITY RW: 1 = active-low / falling edge.
  - 0x10 PENDING R/W1C. W1C affects edge bits only; level bits are read-only.
  - 0x14 RAW R: synchronised source levels, before polarity.
  - 0x18 VECTOR R: [31] valid, [4:0] lowest-index source with pending&ENABLE. valid=0 gives 0. No read side effects.
  - 0x1C ACK W: [4:0]=id clears pending[id] for edge sources. id>=NUM_IRQ is ignored.
  - 0x20 VERSION R: constant 0x2024_0701.
- Read timing:
  - At the edge where bram_rd=1, bram_rd_data is loaded with the addressed value.
  - It holds until the next bram_rd edge. Latency is 1 cycle.
  - The value reflects CSR state before any write in the same cycle.
  - bram_rd and bram_wr are never asserted together; if they are, the write is performed and the read returns pre-write data.
- Writes take effect at the edge where bram_wr=1.
- Source path, per source i:
  - Two-flop synchroniser s1, s2.
  - Adjusted level a = s2 ^ POLARITY[i]; a_prev is registered.
  - Edge mode: pending set when a & ~a_prev.
  - Level mode: pending = a, updated every cycle.
- Latency: irq_src first sampled high at edge E0 → s2 at E1 → pending at E2 → irq at E3.
- Simultaneous set and clear: a source edge in the same cycle as W1C/ACK of that bit leaves the bit set (set wins).
- Writing POLARITY may produce an edge on a; the resulting pending is legitimate. Software clears it.
- Switching EDGE from level to edge keeps the current pending bit value.
- irq <= CTRL[0] & |(pending & ENABLE), registered.
- irq stays high while any enabled bit is pending. Clearing the last bit at edge Ek drops irq at Ek+1.
- ENABLE does not gate pending capture. Unmasking an already-pending bit raises irq one cycle after the ENABLE write.

Decomposition:
- pic_defines.vh: register offset localparams (CSR_CTRL..CSR_VERSION), VERSION constant, VECTOR valid-bit position.
- One sub-module, pic_src_cond:
  - one instance per source via generate;
  - contains synchroniser, polarity XOR, a_prev, edge detect and pending flop with set-wins-over-clear;
  - inputs: edge_mode, polarity, clr.
- The priority encoder, CSR decode and irq register stay in pic_core_csr.

Test Plan:
1. Reset, then read each of 0x00..0x20 → all return 0 except VERSION=0x20240701. irq=0. rdata valid one cycle after bram_rd.
2. CTRL=1, ENABLE=0x0004, EDGE=0x0004. Pulse irq_src[2] high for 1 cycle → irq rises at E3. PENDING=0x0004, VECTOR=0x80000002. Write ACK=2 → irq low next cycle, PENDING=0.
3. Level source 5, POLARITY[5]=1, ENABLE[5]=1, CTRL=1, irq_src[5]=0 → irq=1. Write PENDING=0x20 → no change. Drive irq_src[5]=1 → irq drops 3 edges later.
4. Edge sources 3 and 7 pending → VECTOR=0x80000003. Write PENDING=0x0008 in the same cycle a new edge arrives on 3 (s2 rising) → bit 3 stays set.
5. CTRL=0 with ENABLE=0xFFFF and sources pending → irq=0. Write CTRL=1 → irq=1 the next cycle. Write ACK=31 with NUM_IRQ=16 → no state change.
6. Assert areset mid-read and with pending set → bram_rd_data=0, PENDING=0, irq=0 on the next edge.

Source files
------------

// File: rtl/pic_core_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pic_core_csr_pkg
// Description : CSR map, constants and write-select type for the PIC core.
// Revision    : 1.0 - initial release
// ============================================================================
package pic_core_csr_pkg;

    localparam logic [31:0] CSR_CTRL     = 32'h00;
    localparam logic [31:0] CSR_ENABLE   = 32'h04;
    localparam logic [31:0] CSR_EDGE     = 32'h08;
    localparam logic [31:0] CSR_POLARITY = 32'h0C;
    localparam logic [31:0] CSR_PENDING  = 32'h10;
    localparam logic [31:0] CSR_RAW      = 32'h14;
    localparam logic [31:0] CSR_VECTOR   = 32'h18;
    localparam logic [31:0] CSR_ACK      = 32'h1C;
    localparam logic [31:0] CSR_VERSION  = 32'h20;

    localparam logic [31:0] VERSION_VALUE    = 32'h2024_0701;
    localparam int          VECTOR_VALID_BIT = 31;

    typedef struct packed {
        logic we_ctrl;
        logic we_enable;
        logic we_edge;
        logic we_polarity;
        logic we_pending;
        logic we_ack;
    } csr_wsel_t;

endpackage
`default_nettype wire

// File: rtl/pic_core_csr_src_cond.sv
`default_nettype none
// ============================================================================
// Module      : pic_src_cond
// Description : Per-source synchroniser, polarity adjust, edge/level qualify
//               and pending flop (a new edge wins over a same-cycle clear).
// Revision    : 1.0 - initial release
// ============================================================================
module pic_src_cond (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic edge_mode,
    input  logic polarity,
    input  logic clr,
    output logic sync_level,
    output logic pending
);

    logic r_s1;
    logic r_s2;
    logic r_a_prev;
    logic r_pending;
    logic w_a;
    logic w_rise;

    assign w_a    = r_s2 ^ polarity;
    assign w_rise = w_a & ~r_a_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_a_prev  <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_s1     <= src;
            r_s2     <= r_s1;
            r_a_prev <= w_a;
            if (edge_mode) begin
                r_pending <= w_rise | (r_pending & ~clr);
            end else begin
                r_pending <= w_a;
            end
        end
    end

    assign sync_level = r_s2;
    assign pending    = r_pending;

endmodule
`default_nettype wire

// File: rtl/pic_core_csr.sv
`default_nettype none
// ============================================================================
// Module      : pic_core_csr
// Description : PIC CSR register file, per-source conditioning, priority
//               vector and registered CPU interrupt request.
// Revision    : 1.0 - initial release
// ============================================================================
module pic_core_csr
    import pic_core_csr_pkg::*;
#(
    parameter int ADD_WIDTH = 8,
    parameter int NUM_IRQ   = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [ADD_WIDTH-1:0] bram_addr,
    input  logic                 bram_wr,
    input  logic [31:0]          bram_wr_data,
    input  logic                 bram_rd,
    output logic [31:0]          bram_rd_data,
    input  logic [NUM_IRQ-1:0]   irq_src,
    output logic                 irq
);

    logic               r_ctrl;
    logic [NUM_IRQ-1:0] r_enable;
    logic [NUM_IRQ-1:0] r_edge_mode;
    logic [NUM_IRQ-1:0] r_polarity;
    logic [31:0]        r_rd_data;
    logic               r_irq;

    logic [NUM_IRQ-1:0] w_pending;
    logic [NUM_IRQ-1:0] w_raw;
    logic [NUM_IRQ-1:0] w_clr;
    logic [31:0]        w_addr;
    logic [31:0]        w_rd_mux;
    csr_wsel_t          w_wsel;
    logic               w_vec_valid;
    logic [4:0]         w_vec_id;
    logic               w_unused;

    // Byte-lane bits of the address and high write-data bits carry no state.
    assign w_unused = ^{bram_addr[1:0], bram_wr_data};

    always_comb begin
        w_addr                 = '0;
        w_addr[ADD_WIDTH-1:2]  = bram_addr[ADD_WIDTH-1:2];
    end

    always_comb begin
        w_wsel = '0;
        if (bram_wr) begin
            case (w_addr)
                CSR_CTRL:     w_wsel.we_ctrl     = 1'b1;
                CSR_ENABLE:   w_wsel.we_enable   = 1'b1;
                CSR_EDGE:     w_wsel.we_edge     = 1'b1;
                CSR_POLARITY: w_wsel.we_polarity = 1'b1;
                CSR_PENDING:  w_wsel.we_pending  = 1'b1;
                CSR_ACK:      w_wsel.we_ack      = 1'b1;
                default:      w_wsel             = '0;
            endcase
        end
    end

    // Clear requests from W1C and ACK; level-mode sources ignore them.
    always_comb begin
        w_clr = '0;
        if (w_wsel.we_pending) begin
            w_clr = bram_wr_data[NUM_IRQ-1:0];
        end
        if (w_wsel.we_ack) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (bram_wr_data[4:0] == 5'(i)) begin
                    w_clr[i] = 1'b1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
            pic_src_cond u_src (
                .clk        (aclk),
                .rst        (areset),
                .src        (irq_src[gi]),
                .edge_mode  (r_edge_mode[gi]),
                .polarity   (r_polarity[gi]),
                .clr        (w_clr[gi]),
                .sync_level (w_raw[gi]),
                .pending    (w_pending[gi])
            );
        end
    endgenerate

    // Scan downwards so the lowest-index enabled pending source is kept.
    always_comb begin
        w_vec_valid = 1'b0;
        w_vec_id    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pending[i] & r_enable[i]) begin
                w_vec_valid = 1'b1;
                w_vec_id    = 5'(i);
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_addr)
            CSR_CTRL:     w_rd_mux[0]           = r_ctrl;
            CSR_ENABLE:   w_rd_mux[NUM_IRQ-1:0] = r_enable;
            CSR_EDGE:     w_rd_mux[NUM_IRQ-1:0] = r_edge_mode;
            CSR_POLARITY: w_rd_mux[NUM_IRQ-1:0] = r_polarity;
            CSR_PENDING:  w_rd_mux[NUM_IRQ-1:0] = w_pending;
            CSR_RAW:      w_rd_mux[NUM_IRQ-1:0] = w_raw;
            CSR_VECTOR: begin
                w_rd_mux[VECTOR_VALID_BIT] = w_vec_valid;
                w_rd_mux[4:0]              = w_vec_id;
            end
            CSR_VERSION:  w_rd_mux              = VERSION_VALUE;
            default:      w_rd_mux              = '0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_ctrl      <= 1'b0;
            r_enable    <= '0;
            r_edge_mode <= '0;
            r_polarity  <= '0;
            r_rd_data   <= '0;
            r_irq       <= 1'b0;
        end else begin
            if (w_wsel.we_ctrl) begin
                r_ctrl <= bram_wr_data[0];
            end
            if (w_wsel.we_enable) begin
                r_enable <= bram_wr_data[NUM_IRQ-1:0];
            end
            if (w_wsel.we_edge) begin
                r_edge_mode <= bram_wr_data[NUM_IRQ-1:0];
            end
            if (w_wsel.we_polarity) begin
                r_polarity <= bram_wr_data[NUM_IRQ-1:0];
            end
            if (bram_rd) begin
                r_rd_data <= w_rd_mux;
            end
            r_irq <= r_ctrl & (|(w_pending & r_enable));
        end
    end

    assign bram_rd_data = r_rd_data;
    assign irq          = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_pic_core_csr.sv
`default_nettype none
// ============================================================================
// Module      : tb_pic_core_csr
// Description : Self-checking bench for pic_core_csr: vector table, directed
//               corner sequences and randomized traffic against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_core_csr;

    localparam int          NUM   = 16;
    localparam logic [31:0] C_VER = 32'h2024_0701;

    logic            clk;
    logic            areset;
    logic [7:0]      bram_addr;
    logic            bram_wr;
    logic [31:0]     bram_wr_data;
    logic            bram_rd;
    logic [31:0]     bram_rd_data;
    logic [NUM-1:0]  irq_src;
    logic            irq;

    int checks   = 0;
    int failures = 0;

    pic_core_csr #(.ADD_WIDTH(8), .NUM_IRQ(NUM)) dut (
        .aclk         (clk),
        .areset       (areset),
        .bram_addr    (bram_addr),
        .bram_wr      (bram_wr),
        .bram_wr_data (bram_wr_data),
        .bram_rd      (bram_rd),
        .bram_rd_data (bram_rd_data),
        .irq_src      (irq_src),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-source arrays updated once per clock edge.
    bit          m_ctrl;
    bit          m_en   [NUM];
    bit          m_edge [NUM];
    bit          m_pol  [NUM];
    bit          m_pend [NUM];
    bit          m_s1   [NUM];
    bit          m_s2   [NUM];
    bit          m_aprev[NUM];
    logic [31:0] m_rdata = '0;
    bit          m_irq;

    function automatic logic [31:0] m_csr(input logic [7:0] addr);
        int          w;
        logic [31:0] v;
        w = int'(addr) / 4;
        v = 0;
        case (w)
            0: v = {31'd0, m_ctrl};
            1: for (int i = 0; i < NUM; i++) v[i] = m_en[i];
            2: for (int i = 0; i < NUM; i++) v[i] = m_edge[i];
            3: for (int i = 0; i < NUM; i++) v[i] = m_pol[i];
            4: for (int i = 0; i < NUM; i++) v[i] = m_pend[i];
            5: for (int i = 0; i < NUM; i++) v[i] = m_s2[i];
            6: begin
                for (int i = 0; i < NUM; i++) begin
                    if (m_pend[i] && m_en[i]) begin
                        v = 32'h8000_0000 + i;
                        break;
                    end
                end
            end
            8: v = C_VER;
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic model_edge(input logic rst, input logic rd, input logic wr,
                              input logic [7:0] addr, input logic [31:0] wd,
                              input logic [NUM-1:0] src);
        int          w;
        logic [31:0] rv;
        bit          any;
        bit          a;
        bit          clr;
        w = int'(addr) / 4;
        if (rst) begin
            m_ctrl  = 0;
            m_rdata = 0;
            m_irq   = 0;
            for (int i = 0; i < NUM; i++) begin
                m_en[i] = 0; m_edge[i] = 0; m_pol[i] = 0; m_pend[i] = 0;
                m_s1[i] = 0; m_s2[i] = 0; m_aprev[i] = 0;
            end
            return;
        end
        rv  = m_csr(addr);
        any = 0;
        for (int i = 0; i < NUM; i++) if (m_pend[i] && m_en[i]) any = 1;
        for (int i = 0; i < NUM; i++) begin
            a   = m_s2[i] ^ m_pol[i];
            clr = wr && ((w == 4 && wd[i]) || (w == 7 && int'(wd[4:0]) == i));
            if (m_edge[i]) m_pend[i] = (a && !m_aprev[i]) || (m_pend[i] && !clr);
            else           m_pend[i] = a;
            m_aprev[i] = a;
            m_s2[i]    = m_s1[i];
            m_s1[i]    = src[i];
        end
        if (rd) m_rdata = rv;
        m_irq = m_ctrl && any;
        if (wr) begin
            case (w)
                0: m_ctrl = wd[0];
                1: for (int i = 0; i < NUM; i++) m_en[i]   = wd[i];
                2: for (int i = 0; i < NUM; i++) m_edge[i] = wd[i];
                3: for (int i = 0; i < NUM; i++) m_pol[i]  = wd[i];
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(areset, bram_rd, bram_wr, bram_addr, bram_wr_data, irq_src);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic wr_csr(input logic [7:0] a, input logic [31:0] d);
        bram_addr    = a;
        bram_wr_data = d;
        bram_wr      = 1'b1;
        tick();
        bram_wr      = 1'b0;
    endtask

    task automatic rd_csr(input logic [7:0] a, output logic [31:0] d);
        bram_addr = a;
        bram_rd   = 1'b1;
        tick();
        bram_rd   = 1'b0;
        d         = bram_rd_data;
    endtask

    task automatic do_reset();
        irq_src = '0;
        areset  = 1'b1;
        tick();
        tick();
        areset  = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;

        areset = 1'b1; bram_addr = '0; bram_wr = 1'b0; bram_wr_data = '0;
        bram_rd = 1'b0; irq_src = '0;

        // Reset contents, read-only/unmapped handling, RW masking.
        vecs.push_back('{8'h00, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{8'h04, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{8'h08, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{8'h0C, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{8'h10, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{8'h14, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{8'h18, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{8'h1C, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{8'h20, 1'b0, 32'h0, C_VER});
        vecs.push_back('{8'h23, 1'b0, 32'h0, C_VER});
        vecs.push_back('{8'h24, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{8'h04, 1'b1, 32'hFFFF_FFFF, 32'h0000_FFFF});
        vecs.push_back('{8'h08, 1'b1, 32'hA5A5_A5A5, 32'h0000_A5A5});
        vecs.push_back('{8'h00, 1'b1, 32'hFFFF_FFFE, 32'h0});
        vecs.push_back('{8'h01, 1'b1, 32'h0000_0003, 32'h1});
        vecs.push_back('{8'h14, 1'b1, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{8'h20, 1'b1, 32'h1234_5678, C_VER});
        vecs.push_back('{8'h24, 1'b1, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{8'h00, 1'b1, 32'h0, 32'h0});
        vecs.push_back('{8'h04, 1'b1, 32'h0, 32'h0});

        do_reset();
        chk("reset_irq", {31'd0, irq}, 32'h0);
        chk("reset_rdata", bram_rd_data, 32'h0);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) wr_csr(vecs[i].addr, vecs[i].wdata);
            rd_csr(vecs[i].addr, d);
            chk($sformatf("vec%0d", i), d, vecs[i].exp);
        end
        rd_csr(8'h20, d);
        tick();
        chk("rdata_hold", bram_rd_data, C_VER);

        // Single edge pulse on source 2: irq three edges after first sample.
        do_reset();
        wr_csr(8'h00, 32'h1); wr_csr(8'h04, 32'h4); wr_csr(8'h08, 32'h4);
        irq_src = 16'h0004; tick(); irq_src = '0;
        tick(); tick();
        chk("t2_irq_e2", {31'd0, irq}, 32'h0);
        tick();
        chk("t2_irq_e3", {31'd0, irq}, 32'h1);
        rd_csr(8'h10, d); chk("t2_pending", d, 32'h4);
        rd_csr(8'h18, d); chk("t2_vector", d, 32'h8000_0002);
        wr_csr(8'h1C, 32'd2);
        tick();
        chk("t2_irq_after_ack", {31'd0, irq}, 32'h0);
        rd_csr(8'h10, d); chk("t2_pending_clr", d, 32'h0);

        // Active-low level source 5.
        do_reset();
        wr_csr(8'h0C, 32'h20); wr_csr(8'h04, 32'h20); wr_csr(8'h00, 32'h1);
        tick();
        chk("t3_irq_level", {31'd0, irq}, 32'h1);
        wr_csr(8'h10, 32'h20); tick();
        chk("t3_irq_w1c_level", {31'd0, irq}, 32'h1);
        rd_csr(8'h10, d); chk("t3_pending", d, 32'h20);
        irq_src = 16'h0020;
        tick(); tick(); tick();
        chk("t3_irq_e2", {31'd0, irq}, 32'h1);
        tick();
        chk("t3_irq_e3", {31'd0, irq}, 32'h0);

        // Priority and set-wins-over-W1C.
        do_reset();
        wr_csr(8'h00, 32'h1); wr_csr(8'h04, 32'h88); wr_csr(8'h08, 32'h88);
        irq_src = 16'h0088; tick(); irq_src = '0;
        tick(); tick(); tick();
        rd_csr(8'h18, d); chk("t4_vector", d, 32'h8000_0003);
        irq_src = 16'h0008; tick(); irq_src = '0;
        tick();
        wr_csr(8'h10, 32'h8);
        rd_csr(8'h10, d); chk("t4_set_wins", d, 32'h88);
        wr_csr(8'h10, 32'h8);
        rd_csr(8'h10, d); chk("t4_w1c", d, 32'h80);
        rd_csr(8'h18, d); chk("t4_vector7", d, 32'h8000_0007);

        // Global enable gating and out-of-range ACK.
        do_reset();
        wr_csr(8'h04, 32'hFFFF); wr_csr(8'h08, 32'hFFFF);
        irq_src = 16'h0003; tick(); irq_src = '0;
        tick(); tick(); tick();
        chk("t5_irq_ctrl0", {31'd0, irq}, 32'h0);
        wr_csr(8'h00, 32'h1);
        tick();
        chk("t5_irq_ctrl1", {31'd0, irq}, 32'h1);
        wr_csr(8'h1C, 32'd31);
        rd_csr(8'h10, d); chk("t5_ack31", d, 32'h3);
        wr_csr(8'h1C, 32'd16);
        rd_csr(8'h10, d); chk("t5_ack16", d, 32'h3);

        // Reset during a read with pending set.
        rd_csr(8'h20, d); chk("t6_pre", d, C_VER);
        bram_addr = 8'h20; bram_rd = 1'b1; areset = 1'b1;
        tick();
        bram_rd = 1'b0; areset = 1'b0;
        chk("t6_rdata", bram_rd_data, 32'h0);
        chk("t6_irq", {31'd0, irq}, 32'h0);
        rd_csr(8'h10, d); chk("t6_pending", d, 32'h0);

        // Unmasking an already-pending source.
        do_reset();
        wr_csr(8'h08, 32'h1); wr_csr(8'h00, 32'h1);
        irq_src = 16'h0001; tick(); irq_src = '0;
        tick(); tick(); tick();
        wr_csr(8'h04, 32'h1);
        chk("t7_irq_at_write", {31'd0, irq}, 32'h0);
        tick();
        chk("t7_irq_unmask", {31'd0, irq}, 32'h1);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            int op;
            int word;
            op      = $urandom_range(0, 9);
            word    = $urandom_range(0, 10);
            areset  = ($urandom_range(0, 299) == 0);
            bram_wr = 1'b0;
            bram_rd = 1'b0;
            bram_addr = 8'(word * 4 + $urandom_range(0, 3));
            if (op <= 2) begin
                bram_wr      = 1'b1;
                bram_wr_data = (word == 7) ? 32'($urandom_range(0, 31)) : $urandom;
            end else if (op <= 5) begin
                bram_rd = 1'b1;
            end
            for (int i = 0; i < NUM; i++)
                if ($urandom_range(0, 7) == 0) irq_src[i] = ~irq_src[i];
            tick();
            chk("rand_irq", {31'd0, irq}, {31'd0, m_irq});
            chk("rand_rdata", bram_rd_data, m_rdata);
        end
        areset = 1'b0; bram_wr = 1'b0; bram_rd = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
